// File: rtl/pam4_pkg.sv
// Shared PAM-4 definitions: symbol type, symbol-to-level mapping, slicer
// threshold helpers and a signed saturation helper.
//   pam4_sym_t     : 2-bit symbol, 0..3 maps to -3S/2, -S/2, +S/2, +3S/2
//   pam4_level()   : signed level of a symbol for a given level spacing S
//   pam4_thr_lo/hi : outer slicer thresholds (-S and +S); middle threshold is 0
//   pam4_sat()     : clamp a signed value to a signed w-bit range
package pam4_pkg;

  typedef logic [1:0] pam4_sym_t;

  localparam int PAM4_DEFAULT_SEP = 56;

  function automatic int pam4_level(input pam4_sym_t sym, input int sep);
    int half;
    int lvl;
    half = sep / 2;
    lvl  = 0;
    unique case (sym)
      2'd0: lvl = -3 * half;
      2'd1: lvl = -half;
      2'd2: lvl = half;
      2'd3: lvl = 3 * half;
      default: lvl = 0;
    endcase
    return lvl;
  endfunction

  function automatic int pam4_thr_lo(input int sep);
    return -sep;
  endfunction

  function automatic int pam4_thr_hi(input int sep);
    return sep;
  endfunction

  localparam int PAM4_DEFAULT_THR_LO = -PAM4_DEFAULT_SEP;
  localparam int PAM4_DEFAULT_THR_HI = PAM4_DEFAULT_SEP;

  function automatic logic signed [63:0] pam4_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pam4_slicer.sv
// Combinational PAM-4 slicer. Thresholds are -S, 0, +S; a sample exactly on a
// threshold resolves to the upper symbol.
//   y   : signed equalized sample
//   sym : sliced symbol 0..3
module pam4_slicer
  import pam4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56
) (
  input  logic signed [SIGNAL_RESOLUTION-1:0] y,
  output pam4_sym_t                           sym
);

  localparam int ThrLo = pam4_thr_lo(SYMBOL_SEPERATION);
  localparam int ThrHi = pam4_thr_hi(SYMBOL_SEPERATION);

  always_comb begin
    sym = 2'd0;
    if (int'(y) < ThrLo) begin
      sym = 2'd0;
    end else if (int'(y) < 0) begin
      sym = 2'd1;
    end else if (int'(y) < ThrHi) begin
      sym = 2'd2;
    end else begin
      sym = 2'd3;
    end
  end

endmodule

// File: rtl/pam4_dfe_rx.sv
// PAM-4 receive decision feedback equalizer. Subtracts tap-weighted levels of
// past decisions from each accepted sample, saturates and slices the result.
// One cycle latency; the feedback loop is closed combinationally from the
// decision history register.
//   clk, rstn        : clock, synchronous active-low reset
//   signal_in(_valid): signed channel sample and its qualifier
//   tap_wr_*         : tap coefficient write port (addr 0 = first post-cursor)
//   eq_out           : equalized, saturated sample
//   symbol_out       : sliced decision 0..3
//   symbol_out_valid : qualifier for eq_out/symbol_out
module pam4_dfe_rx
  import pam4_pkg::*;
#(
  parameter int NUM_TAPS          = 2,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int TAP_RESOLUTION    = 8,
  parameter int FRAC_BITS         = 6
) (
  input  logic                                                   clk,
  input  logic                                                   rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                    signal_in,
  input  logic                                                   signal_in_valid,
  input  logic                                                   tap_wr_en,
  input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0]     tap_wr_addr,
  input  logic signed [TAP_RESOLUTION-1:0]                       tap_wr_data,
  output logic signed [SIGNAL_RESOLUTION-1:0]                    eq_out,
  output logic [1:0]                                             symbol_out,
  output logic                                                   symbol_out_valid
);

  localparam int AccW = SIGNAL_RESOLUTION + TAP_RESOLUTION + $clog2(NUM_TAPS) + 2;

  logic signed [TAP_RESOLUTION-1:0] taps_q [NUM_TAPS];
  pam4_sym_t                        hist_q [NUM_TAPS];
  logic [NUM_TAPS-1:0]              hist_vld_q;

  logic signed [AccW-1:0]              isi;
  logic signed [AccW-1:0]              isi_scaled;
  logic signed [AccW-1:0]              diff;
  logic signed [SIGNAL_RESOLUTION-1:0] y;
  pam4_sym_t                           sym;

  // Empty history slots contribute nothing, so the first samples after reset
  // see only as much ISI as there are real past decisions.
  always_comb begin
    isi = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (hist_vld_q[k]) begin
        isi = isi + AccW'(taps_q[k]) * AccW'(pam4_level(hist_q[k], SYMBOL_SEPERATION));
      end
    end
    isi_scaled = isi >>> FRAC_BITS;
    diff       = AccW'(signal_in) - isi_scaled;
    y          = SIGNAL_RESOLUTION'(pam4_sat(64'(diff), SIGNAL_RESOLUTION));
  end

  pam4_slicer #(
    .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION (SYMBOL_SEPERATION)
  ) u_slicer (
    .y   (y),
    .sym (sym)
  );

  // Tap writes land on the same edge as a coinciding sample, so that sample
  // has already used the old coefficient through the combinational path.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        taps_q[k] <= '0;
        hist_q[k] <= '0;
      end
      hist_vld_q       <= '0;
      eq_out           <= '0;
      symbol_out       <= '0;
      symbol_out_valid <= 1'b0;
    end else begin
      if (tap_wr_en && (int'(tap_wr_addr) < NUM_TAPS)) begin
        taps_q[tap_wr_addr] <= tap_wr_data;
      end
      symbol_out_valid <= signal_in_valid;
      if (signal_in_valid) begin
        eq_out        <= y;
        symbol_out    <= sym;
        hist_q[0]     <= sym;
        hist_vld_q[0] <= 1'b1;
        for (int k = 1; k < NUM_TAPS; k++) begin
          hist_q[k]     <= hist_q[k-1];
          hist_vld_q[k] <= hist_vld_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pam4_dfe_rx.sv
module tb_pam4_dfe_rx;

  localparam int NTAPS = 2;
  localparam int SEP   = 56;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic signed [7:0] signal_in = '0;
  logic              signal_in_valid = 1'b0;
  logic              tap_wr_en = 1'b0;
  logic [0:0]        tap_wr_addr = '0;
  logic signed [7:0] tap_wr_data = '0;
  logic signed [7:0] eq_out;
  logic [1:0]        symbol_out;
  logic              symbol_out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pam4_dfe_rx dut (
    .clk              (clk),
    .rstn             (rstn),
    .signal_in        (signal_in),
    .signal_in_valid  (signal_in_valid),
    .tap_wr_en        (tap_wr_en),
    .tap_wr_addr      (tap_wr_addr),
    .tap_wr_data      (tap_wr_data),
    .eq_out           (eq_out),
    .symbol_out       (symbol_out),
    .symbol_out_valid (symbol_out_valid)
  );

  typedef struct {
    string name;
    bit    rst;
    bit    vld;
    int    din;
    bit    we;
    int    wa;
    int    wd;
    bit    ev;
    int    eeq;
    int    esym;
  } step_t;

  step_t steps[$];

  function automatic step_t mk(string name, bit rst, bit vld, int din, bit we, int wa, int wd,
                               bit ev, int eeq, int esym);
    step_t s;
    s.name = name; s.rst = rst; s.vld = vld; s.din = din;
    s.we = we; s.wa = wa; s.wd = wd;
    s.ev = ev; s.eeq = eeq; s.esym = esym;
    return s;
  endfunction

  task automatic check(string name, bit ev, int eeq, int esym);
    total++;
    if (symbol_out_valid !== ev || int'(eq_out) != eeq || int'(symbol_out) != esym ||
        $isunknown({eq_out, symbol_out})) begin
      bad++;
      $display("FAIL %s: got valid=%0b eq=%0d sym=%0d, want valid=%0b eq=%0d sym=%0d",
               name, symbol_out_valid, eq_out, symbol_out, ev, eeq, esym);
    end
  endtask

  task automatic drive(bit rst, bit vld, int din, bit we, int wa, int wd);
    @(negedge clk);
    rstn            = !rst;
    signal_in_valid = vld;
    signal_in       = 8'(din);
    tap_wr_en       = we;
    tap_wr_addr     = 1'(wa);
    tap_wr_data     = 8'(wd);
  endtask

  // Reference model: decisions kept as a most-recent-first queue of symbols.
  int m_taps[NTAPS];
  int m_hist[$];
  bit m_vld;
  int m_eq;
  int m_sym;

  function automatic int lvl(int s);
    return (2 * s - 3) * SEP / 2;
  endfunction

  function automatic int slice(int y);
    if (y < -SEP) return 0;
    if (y < 0)    return 1;
    if (y < SEP)  return 2;
    return 3;
  endfunction

  task automatic model_step(bit rst, bit vld, int din, bit we, int wa, int wd);
    int isi;
    int y;
    if (rst) begin
      foreach (m_taps[k]) m_taps[k] = 0;
      m_hist.delete();
      m_vld = 0; m_eq = 0; m_sym = 0;
      return;
    end
    if (vld) begin
      isi = 0;
      for (int k = 0; k < m_hist.size(); k++) isi += m_taps[k] * lvl(m_hist[k]);
      y = din - (isi >>> 6);
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      m_eq = y;
      m_sym = slice(y);
      m_hist.push_front(m_sym);
      if (m_hist.size() > NTAPS) void'(m_hist.pop_back());
    end
    m_vld = vld;
    if (we && wa < NTAPS) m_taps[wa] = wd;
  endtask

  initial begin
    // name, rst, vld, din, we, wa, wd, exp valid, exp eq, exp sym
    steps.push_back(mk("rst_prio",  1, 1,  84, 1, 0, 50, 0,   0, 0));
    steps.push_back(mk("rst",       1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("zt_84",     0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("zt_28",     0, 1,  28, 0, 0,  0, 1,  28, 2));
    steps.push_back(mk("zt_m28",    0, 1, -28, 0, 0,  0, 1, -28, 1));
    steps.push_back(mk("zt_m84",    0, 1, -84, 0, 0,  0, 1, -84, 0));
    steps.push_back(mk("zt_idle",   0, 0,   5, 0, 0,  0, 0, -84, 0));
    steps.push_back(mk("tie_0",     0, 1,   0, 0, 0,  0, 1,   0, 2));
    steps.push_back(mk("tie_56",    0, 1,  56, 0, 0,  0, 1,  56, 3));
    steps.push_back(mk("tie_m56",   0, 1, -56, 0, 0,  0, 1, -56, 1));
    steps.push_back(mk("tie_55",    0, 1,  55, 0, 0,  0, 1,  55, 2));
    steps.push_back(mk("t2_rst",    1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("t2_wr",     0, 0,   0, 1, 0, 32, 0,   0, 0));
    steps.push_back(mk("t2_84",     0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("t2_70",     0, 1,  70, 0, 0,  0, 1,  28, 2));
    steps.push_back(mk("t2_m14",    0, 1, -14, 0, 0,  0, 1, -28, 1));
    steps.push_back(mk("sat_rst",   1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("sat_wr",    0, 0,   0, 1, 0, -64, 0,  0, 0));
    steps.push_back(mk("sat_84",    0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("sat_100",   0, 1, 100, 0, 0,  0, 1, 127, 3));
    steps.push_back(mk("gap_rst",   1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("gap_wr",    0, 0,   0, 1, 0, 32, 0,   0, 0));
    steps.push_back(mk("gap_84",    0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("gap_idle1", 0, 0, -90, 0, 0,  0, 0,  84, 3));
    steps.push_back(mk("gap_idle2", 0, 0,  12, 0, 0,  0, 0,  84, 3));
    steps.push_back(mk("gap_idle3", 0, 0,   0, 0, 0,  0, 0,  84, 3));
    steps.push_back(mk("gap_70",    0, 1,  70, 0, 0,  0, 1,  28, 2));
    steps.push_back(mk("col_rst",   1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("col_wr",    0, 0,   0, 1, 0, 32, 0,   0, 0));
    steps.push_back(mk("col_84",    0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("col_idle",  0, 0,   0, 0, 0,  0, 0,  84, 3));
    steps.push_back(mk("col_70",    0, 1,  70, 1, 0,  0, 1,  28, 2));
    steps.push_back(mk("col_after", 0, 1,  70, 0, 0,  0, 1,  70, 3));
    steps.push_back(mk("mid_rst",   1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("mid_wr",    0, 0,   0, 1, 0, 32, 0,   0, 0));
    steps.push_back(mk("mid_84",    0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("mid_pulse", 1, 1,  70, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("mid_wr2",   0, 0,   0, 1, 0, 32, 0,   0, 0));
    steps.push_back(mk("mid_70",    0, 1,  70, 0, 0,  0, 1,  70, 3));
    steps.push_back(mk("t1_rst",    1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("t1_wr",     0, 0,   0, 1, 1, 64, 0,   0, 0));
    steps.push_back(mk("t1_84",     0, 1,  84, 0, 0,  0, 1,  84, 3));
    steps.push_back(mk("t1_a",      0, 1,   0, 0, 0,  0, 1,   0, 2));
    steps.push_back(mk("t1_b",      0, 1,   0, 0, 0,  0, 1, -84, 0));
    steps.push_back(mk("fl_rst",    1, 0,   0, 0, 0,  0, 0,   0, 0));
    steps.push_back(mk("fl_wr",     0, 0,   0, 1, 0,  1, 0,   0, 0));
    steps.push_back(mk("fl_m28",    0, 1, -28, 0, 0,  0, 1, -28, 1));
    steps.push_back(mk("fl_0",      0, 1,   0, 0, 0,  0, 1,   1, 2));

    foreach (steps[i]) begin
      drive(steps[i].rst, steps[i].vld, steps[i].din, steps[i].we, steps[i].wa, steps[i].wd);
      @(posedge clk);
      #1;
      check(steps[i].name, steps[i].ev, steps[i].eeq, steps[i].esym);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit rst;
      bit vld;
      bit we;
      int din;
      int wa;
      int wd;
      rst = (i == 0) || ($urandom_range(0, 99) == 0);
      vld = ($urandom_range(0, 3) != 0);
      din = int'($urandom_range(0, 255)) - 128;
      we  = ($urandom_range(0, 9) == 0);
      wa  = int'($urandom_range(0, 1));
      wd  = int'($urandom_range(0, 255)) - 128;
      drive(rst, vld, din, we, wa, wd);
      model_step(rst, vld, din, we, wa, wd);
      @(posedge clk);
      #1;
      check("rnd", m_vld, m_eq, m_sym);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pam4_dfe_rx.md
Name: pam4_dfe_rx

Overview:
Receive-side decision feedback equalizer for the PAM-4 SERDES link. It takes the ISI-corrupted sample stream produced by the channel model and cancels post-cursor ISI by subtracting tap-weighted past decisions. It then slices the result to a 2-bit PAM-4 symbol. It sits between the channel model output and the Rx symbol checker.

Parameters:
NUM_TAPS, 2, number of post-cursor feedback taps (pulse response length minus 1).
SIGNAL_RESOLUTION, 8, bit width of signed input and equalized samples.
SYMBOL_SEPERATION, 56, spacing between PAM-4 levels; must be even; levels are {-3S/2,-S/2,S/2,3S/2}, giving {-84,-28,28,84} at the default.
TAP_RESOLUTION, 8, bit width of signed tap coefficients.
FRAC_BITS, 6, fractional bits of tap coefficients; 64 represents 1.0.

Ports:
clk  in  1  clock.
rstn  in  1  synchronous, active-low reset.
signal_in  in  SIGNAL_RESOLUTION  signed channel sample.
signal_in_valid  in  1  sample qualifier.
tap_wr_en  in  1  tap coefficient write strobe.
tap_wr_addr  in  $clog2(NUM_TAPS) (min 1)  tap index; 0 is the first post-cursor.
tap_wr_data  in  TAP_RESOLUTION  signed coefficient.
eq_out  out  SIGNAL_RESOLUTION  signed equalized sample y[n].
symbol_out  out  2  sliced symbol d[n], in the range 0..3.
symbol_out_valid  out  1  qualifier for eq_out and symbol_out.

Behaviour:
- Reset (rstn low at a posedge):
  - symbol_out_valid=0, eq_out=0, symbol_out=0.
  - All taps cleared to 0.
  - Decision history cleared and all history entries marked empty.
  - Reset mid-stream discards all history; the first sample after reset sees zero ISI.
- Per accepted sample (signal_in_valid=1):
  - isi = sum over k of tap[k]*level(d[n-1-k]), computed over non-empty history entries only. Empty entries contribute 0.
  - The accumulator is at least SIGNAL_RESOLUTION+TAP_RESOLUTION+$clog2(NUM_TAPS)+2 bits wide, so no internal overflow.
  - isi is arithmetic-shifted right by FRAC_BITS (floor rounding).
  - y = signal_in - isi, saturated to the signed SIGNAL_RESOLUTION range.
  - Slicer thresholds are -S, 0, +S:
    - y < -S gives 0.
    - -S <= y < 0 gives 1.
    - 0 <= y < S gives 2.
    - y >= S gives 3.
    - A value equal to a threshold goes to the upper symbol.
- Latency and feedback:
  - Latency is exactly 1 cycle: eq_out, symbol_out and symbol_out_valid are registered on the edge where the sample is accepted.
  - The feedback path uses d[n-1] in the same cycle; it is combinational from the history register, with no loop pipelining.
  - The history shift register shifts in d[n] and its valid flag only on accepted samples.
- Idle cycles: when signal_in_valid=0, symbol_out_valid goes to 0 on the next edge. eq_out and symbol_out hold their values, and the history is unchanged.
- Tap writes:
  - A tap write takes effect at the edge where tap_wr_en is sampled.
  - If a write coincides with a valid sample, that sample uses the old coefficient; the new value applies from the next sample.
  - Writes with tap_wr_addr >= NUM_TAPS are ignored.
  - rstn low takes priority over both tap writes and samples.
- Symbol mapping is fixed: 0,1,2,3 map to -3S/2, -S/2, +S/2, +3S/2.

Decomposition:
- Shared package pam4_pkg:
  - typedef pam4_sym_t (logic [1:0]).
  - Function pam4_level(sym, sep) returning a signed level.
  - Threshold constants derived from SYMBOL_SEPERATION.
  - Saturation helper function.
- One natural sub-module: pam4_slicer, combinational. It maps y to a symbol and is reusable by the Tx-side checker.
- The top level holds the tap register file, the history shift register, the MAC/saturation logic and the output registers.

Test Plan:
- Zero taps, with consecutive valid inputs 84, 28, -28, -84. Required: one cycle later, symbols 3, 2, 1, 0, eq_out equal to the inputs, and symbol_out_valid high for 4 cycles.
- Write tap0=32 (0.5), then send inputs 84, 70, -14. Required:
  - Symbols 3, 2, 1.
  - eq_out 84, 28, -28 (isi 42 then 14).
- Zero taps, threshold ties: inputs 0, 56, -56, 55. Required: symbols 2, 3, 1, 2.
- Saturation: tap0=-64, then inputs 84, 100. Required: the second output has eq_out=127 (184 clamped) and symbol 3.
- Valid gaps and write collision, with tap0=32:
  - Send 84, then 3 idle cycles, then 70. Required: symbol 2, because the history was held across the gap and symbol_out_valid was low during the idle cycles.
  - Repeat with tap0 rewritten to 0 in the same cycle as the 70. Required: the old tap is still used, giving eq_out 28.
- Reset mid-stream: after the 84 with tap0=32, pulse rstn, rewrite tap0=32, then send 70. Required: eq_out 70 and symbol 3 (history cleared), and valid was 0 during reset.
